// File: rtl/recip_pkg.sv
// rtl/recip_pkg.sv - shared state encoding and round-mode constant for recip_unit
package recip_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    DIV  = ST_DIV,
    DONE = ST_DONE
  } state_t;

  localparam logic ROUND_HALF_UP = 1'b1;

endpackage

// File: rtl/recip_step.sv
// rtl/recip_step.sv - one combinational restoring-division step (shift in a bit, trial subtract)
module recip_step #(
  parameter int W = 16
) (
  input  logic [W:0]   rem,
  input  logic         nbit,
  input  logic [W-1:0] d,
  output logic [W:0]   rem_next,
  output logic         qbit
);

  logic [W+1:0] trial;
  logic [W:0]   diff;

  always_comb begin
    trial    = {rem, nbit};
    qbit     = (trial >= {2'b00, d});
    // when qbit is set the difference is below d, so W+1 bits always hold it
    diff     = trial[W:0] - {1'b0, d};
    rem_next = qbit ? diff : trial[W:0];
  end

endmodule

// File: rtl/recip_unit.sv
// rtl/recip_unit.sv - iterative Q1.(W-1) reciprocal engine, 1 quotient bit per DIV cycle
module recip_unit
  import recip_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Round,
  input  logic [W-1:0]     Divisor,
  output logic [W-1:0]     Result,
  output logic             Ack,
  output logic             Busy,
  output logic             DivZero,
  output logic [CNT_W-1:0] CycleCt
);

  localparam int BC_W = $clog2(W + 1);
  localparam logic [BC_W-1:0] BC_TOP = BC_W'(W);
  localparam logic [BC_W-1:0] BC_ONE = BC_W'(1);
  localparam logic [CNT_W-1:0] CT_ONE = CNT_W'(1);

  state_t          state, next_state;
  logic [W-1:0]    d_q;
  logic            round_q;
  logic            zero_q;
  logic [W:0]      rem;
  logic [W:0]      q;
  logic [BC_W-1:0] bitcnt;
  logic            nbit;
  logic [W:0]      rem_next;
  logic            qbit;
  logic            round_bit;

  // numerator is 2^W: only the top bit is set
  assign nbit      = (bitcnt == BC_TOP);
  assign round_bit = (round_q == ROUND_HALF_UP) & q[0];
  assign Busy      = (state == LOAD) || (state == DIV);

  recip_step #(.W(W)) u_step (
    .rem      (rem),
    .nbit     (nbit),
    .d        (d_q),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Start) next_state = LOAD;
      LOAD:    next_state = DIV;
      DIV:     if (bitcnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      d_q     <= '0;
      round_q <= 1'b0;
      zero_q  <= 1'b0;
      rem     <= '0;
      q       <= '0;
      bitcnt  <= '0;
      Result  <= '0;
      Ack     <= 1'b0;
      DivZero <= 1'b0;
      CycleCt <= '0;
    end else begin
      state <= next_state;
      if (state != IDLE && CycleCt != '1) CycleCt <= CycleCt + CT_ONE;
      case (state)
        IDLE: begin
          if (Start) begin
            d_q     <= Divisor;
            round_q <= Round;
            Ack     <= 1'b0;
            DivZero <= 1'b0;
            CycleCt <= '0;
          end
        end
        LOAD: begin
          rem    <= '0;
          q      <= '0;
          zero_q <= (d_q == '0);
          // a zero divisor spends a single idle DIV cycle so its latency is 3
          bitcnt <= (d_q == '0) ? '0 : BC_TOP;
        end
        DIV: begin
          if (!zero_q) begin
            rem <= rem_next;
            q   <= {q[W-1:0], qbit};
          end
          if (bitcnt != '0) bitcnt <= bitcnt - BC_ONE;
        end
        DONE: begin
          Ack     <= 1'b1;
          DivZero <= zero_q;
          Result  <= zero_q ? '1 : q[W:1] + W'(round_bit);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_unit.sv
// tb/tb_recip_unit.sv - scoreboard bench for recip_unit at W=16, 8 and 24
module tb_recip_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  start;
  logic [31:0] divisor;
  logic        rnd;

  logic [15:0] res16;
  logic [7:0]  res8;
  logic [23:0] res24;
  logic [2:0]  ack, busy, dz;
  logic [7:0]  ct16, ct8, ct24;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          ct;
  } exp_t;
  exp_t sb[$];

  recip_unit #(.W(16), .CNT_W(8)) u16 (
    .Clk(clk), .Reset(rst), .Start(start[0]), .Round(rnd), .Divisor(divisor[15:0]),
    .Result(res16), .Ack(ack[0]), .Busy(busy[0]), .DivZero(dz[0]), .CycleCt(ct16)
  );
  recip_unit #(.W(8), .CNT_W(8)) u8 (
    .Clk(clk), .Reset(rst), .Start(start[1]), .Round(rnd), .Divisor(divisor[7:0]),
    .Result(res8), .Ack(ack[1]), .Busy(busy[1]), .DivZero(dz[1]), .CycleCt(ct8)
  );
  recip_unit #(.W(24), .CNT_W(8)) u24 (
    .Clk(clk), .Reset(rst), .Start(start[2]), .Round(rnd), .Divisor(divisor[23:0]),
    .Result(res24), .Ack(ack[2]), .Busy(busy[2]), .DivZero(dz[2]), .CycleCt(ct24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic int width_of(input int s);
    return (s == 0) ? 16 : (s == 1) ? 8 : 24;
  endfunction

  function automatic logic [31:0] res_of(input int s);
    return (s == 0) ? {16'd0, res16} : (s == 1) ? {24'd0, res8} : {8'd0, res24};
  endfunction

  function automatic logic [31:0] ct_of(input int s);
    return (s == 0) ? {24'd0, ct16} : (s == 1) ? {24'd0, ct8} : {24'd0, ct24};
  endfunction

  function automatic logic [31:0] model(input int w, input logic [31:0] d, input bit r);
    logic [63:0] q;
    logic [63:0] ones;
    ones = (64'd1 << w) - 64'd1;
    if (d == 32'd0) return ones[31:0];
    q = (64'd1 << w) / {32'd0, d};
    q = (q >> 1) + (r ? (q & 64'd1) : 64'd0);
    return q[31:0];
  endfunction

  task automatic run_op(input int s, input logic [31:0] d, input bit r, input bit disturb);
    exp_t e;
    int   w;
    int   k;
    w     = width_of(s);
    e.res = model(w, d, r);
    e.dz  = (d == 32'd0);
    e.ct  = (d == 32'd0) ? 3 : w + 3;
    sb.push_back(e);
    @(negedge clk);
    divisor  = d;
    rnd      = r;
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    check($sformatf("busy_load w%0d", w), {31'd0, busy[s]}, 32'd1);
    check($sformatf("ack_clr w%0d", w), {31'd0, ack[s]}, 32'd0);
    k = 0;
    while (!ack[s] && k < 200) begin
      if (disturb && k < 6) begin
        start[s] = ~start[s];
        divisor  = 32'd3;
        rnd      = ~rnd;
      end
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    check($sformatf("latency w%0d d=%0h", w, d), k, e.ct);
    check($sformatf("result w%0d d=%0h r=%0d", w, d, r), res_of(s), e.res);
    check($sformatf("divzero w%0d d=%0h", w, d), {31'd0, dz[s]}, {31'd0, e.dz});
    check($sformatf("cyclect w%0d d=%0h", w, d), ct_of(s), e.ct);
    check($sformatf("busy_done w%0d", w), {31'd0, busy[s]}, 32'd0);
  endtask

  initial begin
    int          s;
    logic [31:0] d;
    logic [31:0] mask;
    rst     = 1'b1;
    start   = 3'b000;
    divisor = 32'd0;
    rnd     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", {16'd0, res16}, 32'd0);
    check("rst_ack", {29'd0, ack}, 32'd0);
    check("rst_busy", {29'd0, busy}, 32'd0);
    check("rst_cyclect", {24'd0, ct16}, 32'd0);
    rst = 1'b0;

    run_op(0, 32'd3, 1'b0, 1'b0);
    check("tv_div3_trunc", {16'd0, res16}, 32'h2AAA);
    repeat (3) @(negedge clk);
    check("stable_result", {16'd0, res16}, 32'h2AAA);
    check("stable_ack", {31'd0, ack[0]}, 32'd1);
    run_op(0, 32'd3, 1'b1, 1'b0);
    check("tv_div3_round", {16'd0, res16}, 32'h2AAB);
    run_op(0, 32'd4, 1'b1, 1'b0);
    check("tv_div4_round", {16'd0, res16}, 32'h2000);
    run_op(0, 32'd1, 1'b0, 1'b0);
    check("tv_div1", {16'd0, res16}, 32'h8000);
    run_op(0, 32'd0, 1'b0, 1'b0);
    check("tv_div0", {16'd0, res16}, 32'hFFFF);
    run_op(0, 32'd2, 1'b0, 1'b0);
    check("tv_div2", {16'd0, res16}, 32'h4000);

    @(negedge clk);
    divisor  = 32'd7;
    rnd      = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_result", {16'd0, res16}, 32'd0);
    check("midrst_ack", {31'd0, ack[0]}, 32'd0);
    check("midrst_busy", {31'd0, busy[0]}, 32'd0);
    check("midrst_dz", {31'd0, dz[0]}, 32'd0);
    check("midrst_ct", {24'd0, ct16}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 32'd5, 1'b0, 1'b0);
    check("tv_div5_after_rst", {16'd0, res16}, 32'h1999);

    run_op(0, 32'd9, 1'b0, 1'b1);
    check("tv_ignore_busy", {16'd0, res16}, 32'h0E38);

    run_op(1, 32'd255, 1'b1, 1'b0);
    run_op(2, 32'hFFFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      s    = (i % 2 == 0) ? 1 : 2;
      mask = (32'd1 << width_of(s)) - 32'd1;
      d    = (i % 7 == 0) ? 32'd0 : ($urandom & mask);
      run_op(s, d, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
